// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared memory port between an instruction
// fetch unit (IFU, read-only) and a load/store unit (LSU).
// Only one transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> IDLE.
// When both requesters are valid together, the one not granted last wins.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   ifu_req_* / ifu_rsp_valid IFU request handshake and response strobe
//   lsu_req_* / lsu_rsp_valid LSU request handshake and response strobe
//   rsp_rdata                 read data shared by both requesters (0 when idle)
//   mem_req_* / mem_rsp_*     downstream memory request and response
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [XLEN-1:0]   ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [XLEN-1:0]   lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [XLEN-1:0]   lsu_req_wdata,
    input  logic [XLEN/8-1:0] lsu_req_wstrb,
    output logic              lsu_rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // requester owning the transaction
    logic              last_q,  last_d;    // requester granted most recently
    logic [XLEN-1:0]   addr_q,  addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              wen_q,   wen_d;
    logic [XLEN/8-1:0] wstrb_q, wstrb_d;
    logic              grant_lsu, grant_ifu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= GNT_IFU;
            last_q  <= GNT_IFU;   // makes LSU win the first tie
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wen_d         = wen_q;
        wstrb_d       = wstrb_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        rsp_rdata     = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;

        // LSU wins unless the IFU is also asking and the LSU went last.
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == GNT_IFU));
        grant_ifu = ifu_req_valid && !grant_lsu;

        unique case (state_q)
            S_IDLE: begin
                // Ready is gated by reset so outputs are 0 while reset is held,
                // even though requests may already be valid.
                if (rst && grant_lsu) begin
                    lsu_req_ready = 1'b1;
                    owner_d       = GNT_LSU;
                    last_d        = GNT_LSU;
                    addr_d        = lsu_req_addr;
                    wen_d         = lsu_req_wen;
                    wdata_d       = lsu_req_wdata;
                    wstrb_d       = lsu_req_wstrb;
                    state_d       = S_ISSUE;
                end else if (rst && grant_ifu) begin
                    ifu_req_ready = 1'b1;
                    owner_d       = GNT_IFU;
                    last_d        = GNT_IFU;
                    addr_d        = ifu_req_addr;
                    wen_d         = 1'b0;
                    wdata_d       = '0;
                    wstrb_d       = '0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_wen   = wen_q;
                mem_req_wdata = wdata_q;
                mem_req_wstrb = wstrb_q;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_rdata     = mem_rsp_rdata;
                    ifu_rsp_valid = (owner_q == GNT_IFU);
                    lsu_rsp_valid = (owner_q == GNT_LSU);
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ifu_req_valid  input  1  IFU fetch request.
REQ-005 SHALL have ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-006 SHALL have ifu_req_addr  input  XLEN  IFU fetch address.
REQ-007 SHALL have ifu_rsp_valid  output  1  IFU read data valid on rsp_rdata.
REQ-008 SHALL have lsu_req_valid  input  1  LSU access request.
REQ-009 SHALL have lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-010 SHALL have lsu_req_addr  input  XLEN  LSU address.
REQ-011 SHALL have lsu_req_wen  input  1  1 = store, 0 = load.
REQ-012 SHALL have lsu_req_wdata  input  XLEN  store data.
REQ-013 SHALL have lsu_req_wstrb  input  XLEN/8  store byte enables.
REQ-014 SHALL have lsu_rsp_valid  output  1  LSU load data valid / store acknowledged.
REQ-015 SHALL have rsp_rdata  output  XLEN  read data, shared by both requesters.
REQ-016 SHALL have mem_req_valid  output  1  request to memory.
REQ-017 SHALL have mem_req_ready  input  1  memory accepts request.
REQ-018 SHALL have mem_req_addr  output  XLEN  memory address.
REQ-019 SHALL have mem_req_wen  output  1  memory write enable.
REQ-020 SHALL have mem_req_wdata  output  XLEN  memory write data.
REQ-021 SHALL have mem_req_wstrb  output  XLEN/8  memory byte enables.
REQ-022 SHALL have mem_rsp_valid  input  1  memory response (read data or write ack).
REQ-023 SHALL have mem_rsp_rdata  input  XLEN  memory read data.

Function
REQ-024 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with at most one outstanding transaction.
REQ-025 In IDLE with any request valid, SHALL grant one requester: assert its req_ready for exactly one cycle, latch addr/wen/wdata/wstrb and owner, and go to ISSUE.
REQ-026 IFU grants SHALL latch wen=0 and wstrb=0.
REQ-027 On simultaneous IFU and LSU requests, SHALL use round-robin arbitration: grant the requester not granted last; a single valid requester is always granted.
REQ-028 In ISSUE, SHALL drive mem_req_valid=1 with the latched fields, and go to WAIT on the cycle mem_req_ready=1.
REQ-029 In ISSUE, mem_req_* fields SHALL stay stable while mem_req_ready=0.
REQ-030 In WAIT, on mem_rsp_valid=1, SHALL pulse the owner's rsp_valid for that same cycle (combinational), drive rsp_rdata=mem_rsp_rdata, and return to IDLE.
REQ-031 Minimum latency SHALL be: req accepted at T, mem_req_valid at T+1, rsp_valid at T+2 when memory is zero-wait.
REQ-032 req_ready SHALL be 0 outside IDLE; a new grant SHALL be possible in the cycle following the response.
REQ-033 mem_rsp_valid received in IDLE or ISSUE SHALL be ignored and produce no rsp_valid.
REQ-034 rsp_rdata SHALL be 0 whenever neither rsp_valid is asserted.
REQ-035 mem_req_addr/wen/wdata/wstrb SHALL be 0 whenever mem_req_valid=0.

Reset
REQ-036 While rst=0, SHALL force state IDLE, last-grant pointer=IFU (LSU wins the first tie), and all outputs to 0, independent of clk.
REQ-037 Reset asserted mid-ISSUE or mid-WAIT SHALL discard the transaction, and no response SHALL be delivered after reset release.

Verification
REQ-038 Reset release, both valid, addresses 0x80000000 (IFU) and 0x80001000 (LSU load), zero-wait memory -> LSU granted first, then IFU; each rsp_valid occurs 2 cycles after its grant.
REQ-039 Both requests held continuously for 6 transactions -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
REQ-040 LSU store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, mem_req_ready held low 3 cycles -> mem_req_* stable for 4 cycles, then lsu_rsp_valid on the ack cycle.
REQ-041 IFU read with mem_rsp_valid delayed 5 cycles, mem_rsp_rdata 0x00100073 -> ifu_rsp_valid=1 and rsp_rdata=0x00100073 in that single cycle only; lsu_rsp_valid remains 0.
REQ-042 rst pulled low during WAIT, then spurious mem_rsp_valid after release -> all outputs 0 during reset, state IDLE, and no rsp_valid.
